// File: rtl/pipeline_mem_stage.sv
// RV32 memory stage: EX/MEM register, req/gnt/rvalid data-memory access, load alignment, MEM/WB register.
// Optional MEM_MISALIGN_TRAP_EN: misaligned half/word accesses raise misalign_exc_o instead of being issued.
module pipeline_mem_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              valid_e_i,
  input  logic [31:0]       alu_result_e_i,
  input  logic [31:0]       mem_wdata_e_i,
  input  logic [31:0]       extended_imm_e_i,
  input  logic [31:0]       pc_plus4_e_i,
  input  logic [31:0]       CSR_data_e_i,
  input  logic              reg_write_en_e_i,
  input  logic [4:0]        rd_idx_e_i,
  input  logic [4:0]        result_src_e_i,
  input  logic              mem_read_e_i,
  input  logic              mem_write_e_i,
  input  logic [2:0]        mem_funct3_e_i,
  input  logic              flush_m_i,
  output logic              stall_m_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [31:0]       dmem_wdata_o,
  output logic [3:0]        dmem_be_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [31:0]       dmem_rdata_i,
  output logic [31:0]       alu_result_m_o,
  output logic [31:0]       mem_read_data_m_o,
  output logic [31:0]       extended_imm_m_o,
  output logic [31:0]       pc_plus4_m_o,
  output logic [31:0]       CSR_data_m_o,
  output logic              reg_write_en_m_o,
  output logic [4:0]        rd_idx_m_o,
  output logic [4:0]        result_src_m_o,
  output logic              misalign_exc_o
);
  typedef enum logic {ACCESS, RDATA} state_t;
  state_t r_state, w_state_nxt;

  logic        r_valid, r_we, r_mrd, r_mwr;
  logic [31:0] r_alu, r_wdata, r_imm, r_pc4, r_csr;
  logic [4:0]  r_rd, r_src;
  logic [2:0]  r_f3;

  logic        w_is_load, w_is_store, w_memop, w_sz_b, w_sz_h;
  logic        w_acc, w_exc, w_done;
  logic [1:0]  w_a, w_off;
  logic [31:0] w_shift, w_ldata;

  assign w_is_load  = r_mrd;
  assign w_is_store = r_mwr & ~r_mrd;
  assign w_memop    = r_valid & (r_mrd | r_mwr);
  assign w_a        = r_alu[1:0];
  // Undefined funct3 codes fall through to word size.
  assign w_sz_b     = (r_f3 == 3'b000) | (w_is_load & (r_f3 == 3'b100));
  assign w_sz_h     = (r_f3 == 3'b001) | (w_is_load & (r_f3 == 3'b101));
  assign w_off      = w_sz_b ? w_a : (w_sz_h ? {w_a[1], 1'b0} : 2'b00);

`ifdef MEM_MISALIGN_TRAP_EN
  logic w_misal;
  assign w_misal = w_memop & ((w_sz_h & w_a[0]) | (~w_sz_b & ~w_sz_h & (|w_a)));
  assign w_exc   = w_misal;
`else
  assign w_exc   = 1'b0;
`endif

  assign w_acc          = w_memop & ~w_exc;
  assign misalign_exc_o = w_exc;
  assign stall_m_o      = w_acc & ~w_done;

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b1;
    dmem_req_o  = 1'b0;
    case (r_state)
      ACCESS: if (w_acc) begin
        dmem_req_o = 1'b1;
        w_done     = w_is_store & dmem_gnt_i;
        if (w_is_load & dmem_gnt_i) w_state_nxt = RDATA;
      end
      RDATA: begin
        w_done = dmem_rvalid_i;
        if (dmem_rvalid_i) w_state_nxt = ACCESS;
      end
      default: w_state_nxt = ACCESS;
    endcase
  end

  // Request fields come straight from the held EX/MEM register, so they stay stable until gnt.
  assign dmem_we_o   = w_is_store;
  assign dmem_addr_o = {r_alu[ADDR_W-1:2], 2'b00};

  always_comb begin
    dmem_wdata_o = r_wdata;
    dmem_be_o    = 4'b1111;
    if (w_sz_b) begin
      dmem_wdata_o = {4{r_wdata[7:0]}};
      dmem_be_o    = 4'b0001 << w_off;
    end else if (w_sz_h) begin
      dmem_wdata_o = {2{r_wdata[15:0]}};
      dmem_be_o    = 4'b0011 << w_off;
    end
  end

  assign w_shift = dmem_rdata_i >> {w_off, 3'b000};

  always_comb begin
    w_ldata = w_shift;
    if (w_sz_b)
      w_ldata = r_f3[2] ? {24'b0, w_shift[7:0]} : {{24{w_shift[7]}}, w_shift[7:0]};
    else if (w_sz_h)
      w_ldata = r_f3[2] ? {16'b0, w_shift[15:0]} : {{16{w_shift[15]}}, w_shift[15:0]};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ACCESS;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_mrd   <= 1'b0;
      r_mwr   <= 1'b0;
      r_alu   <= '0;
      r_wdata <= '0;
      r_imm   <= '0;
      r_pc4   <= '0;
      r_csr   <= '0;
      r_rd    <= '0;
      r_src   <= '0;
      r_f3    <= '0;
    end else if (!stall_m_o) begin
      r_valid <= valid_e_i & ~flush_m_i;
      r_we    <= reg_write_en_e_i;
      r_mrd   <= mem_read_e_i;
      r_mwr   <= mem_write_e_i;
      r_alu   <= alu_result_e_i;
      r_wdata <= mem_wdata_e_i;
      r_imm   <= extended_imm_e_i;
      r_pc4   <= pc_plus4_e_i;
      r_csr   <= CSR_data_e_i;
      r_rd    <= rd_idx_e_i;
      r_src   <= result_src_e_i;
      r_f3    <= mem_funct3_e_i;
    end
  end

  // Anything not completing this cycle (empty, stalled, trapped) leaves an all-zero bubble.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      alu_result_m_o    <= '0;
      mem_read_data_m_o <= '0;
      extended_imm_m_o  <= '0;
      pc_plus4_m_o      <= '0;
      CSR_data_m_o      <= '0;
      reg_write_en_m_o  <= 1'b0;
      rd_idx_m_o        <= '0;
      result_src_m_o    <= '0;
    end else if (r_valid & w_done & ~w_exc) begin
      alu_result_m_o    <= r_alu;
      mem_read_data_m_o <= w_is_load ? w_ldata : 32'h0;
      extended_imm_m_o  <= r_imm;
      pc_plus4_m_o      <= r_pc4;
      CSR_data_m_o      <= r_csr;
      reg_write_en_m_o  <= r_we;
      rd_idx_m_o        <= r_rd;
      result_src_m_o    <= r_src;
    end else begin
      alu_result_m_o    <= '0;
      mem_read_data_m_o <= '0;
      extended_imm_m_o  <= '0;
      pc_plus4_m_o      <= '0;
      CSR_data_m_o      <= '0;
      reg_write_en_m_o  <= 1'b0;
      rd_idx_m_o        <= '0;
      result_src_m_o    <= '0;
    end
  end
endmodule

// File: tb/tb_pipeline_mem_stage.sv
// Bench for pipeline_mem_stage: vector table, hand-written stall/reset/misalign sequences, random ops vs. a reference model.
module tb_pipeline_mem_stage;
  logic        clk = 1'b0;
  logic        resetn;
  logic        valid_e_i, reg_write_en_e_i, mem_read_e_i, mem_write_e_i, flush_m_i;
  logic [31:0] alu_result_e_i, mem_wdata_e_i, extended_imm_e_i, pc_plus4_e_i, CSR_data_e_i;
  logic [4:0]  rd_idx_e_i, result_src_e_i;
  logic [2:0]  mem_funct3_e_i;
  logic        stall_m_o, dmem_req_o, dmem_we_o, dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic [3:0]  dmem_be_o;
  logic [31:0] alu_result_m_o, mem_read_data_m_o, extended_imm_m_o, pc_plus4_m_o, CSR_data_m_o;
  logic        reg_write_en_m_o, misalign_exc_o;
  logic [4:0]  rd_idx_m_o, result_src_m_o;

  always #5 clk = ~clk;

  pipeline_mem_stage #(.ADDR_W(32)) dut (
    .clk(clk), .resetn(resetn), .valid_e_i(valid_e_i), .alu_result_e_i(alu_result_e_i),
    .mem_wdata_e_i(mem_wdata_e_i), .extended_imm_e_i(extended_imm_e_i), .pc_plus4_e_i(pc_plus4_e_i),
    .CSR_data_e_i(CSR_data_e_i), .reg_write_en_e_i(reg_write_en_e_i), .rd_idx_e_i(rd_idx_e_i),
    .result_src_e_i(result_src_e_i), .mem_read_e_i(mem_read_e_i), .mem_write_e_i(mem_write_e_i),
    .mem_funct3_e_i(mem_funct3_e_i), .flush_m_i(flush_m_i), .stall_m_o(stall_m_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i), .alu_result_m_o(alu_result_m_o),
    .mem_read_data_m_o(mem_read_data_m_o), .extended_imm_m_o(extended_imm_m_o),
    .pc_plus4_m_o(pc_plus4_m_o), .CSR_data_m_o(CSR_data_m_o), .reg_write_en_m_o(reg_write_en_m_o),
    .rd_idx_m_o(rd_idx_m_o), .result_src_m_o(result_src_m_o), .misalign_exc_o(misalign_exc_o)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // kind: 0 = non-memory, 1 = load, 2 = store
  typedef struct {
    int          kind;
    logic [2:0]  f3;
    logic [31:0] addr, wd, rdat;
    logic [4:0]  rd;
    int          gd, rvd;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_ld;
  } vec_t;

  function automatic vec_t mk(int kind, logic [2:0] f3, logic [31:0] addr, logic [31:0] wd,
                              logic [31:0] rdat, int gd, int rvd, logic [31:0] e_addr,
                              logic [3:0] e_be, logic [31:0] e_wd, logic [31:0] e_ld);
    vec_t v;
    v.kind = kind; v.f3 = f3; v.addr = addr; v.wd = wd; v.rdat = rdat; v.rd = 5'd1;
    v.gd = gd; v.rvd = rvd; v.e_addr = e_addr; v.e_be = e_be; v.e_wd = e_wd; v.e_ld = e_ld;
    return v;
  endfunction

  // Reference: access size in bytes, offset rounded down to that size, arithmetic extension.
  function automatic vec_t model(vec_t v);
    int sz, off;
    logic [31:0] t;
    if (v.kind == 1) sz = (v.f3 == 0 || v.f3 == 4) ? 1 : (v.f3 == 1 || v.f3 == 5) ? 2 : 4;
    else             sz = (v.f3 == 0) ? 1 : (v.f3 == 1) ? 2 : 4;
    off      = (int'(v.addr[1:0]) / sz) * sz;
    v.e_addr = v.addr & 32'hFFFF_FFFC;
    v.e_be   = 4'(((1 << sz) - 1) << off);
    v.e_wd   = (sz == 1) ? {24'b0, v.wd[7:0]} * 32'h0101_0101 :
               (sz == 2) ? {16'b0, v.wd[15:0]} * 32'h0001_0001 : v.wd;
    t = v.rdat >> (8 * off);
    if (sz == 1) begin
      t = t & 32'hFF;
      if (v.f3 == 0 && t >= 32'd128) t = t - 32'd256;
    end else if (sz == 2) begin
      t = t & 32'hFFFF;
      if (v.f3 == 1 && t >= 32'd32768) t = t - 32'd65536;
    end
    v.e_ld = t;
    return v;
  endfunction

  task automatic drive_ex(input vec_t v);
    valid_e_i        = 1'b1;
    alu_result_e_i   = v.addr;
    mem_wdata_e_i    = v.wd;
    extended_imm_e_i = v.wd;
    pc_plus4_e_i     = v.addr + 32'd4;
    CSR_data_e_i     = v.rdat;
    reg_write_en_e_i = 1'b1;
    rd_idx_e_i       = v.rd;
    mem_read_e_i     = (v.kind == 1);
    mem_write_e_i    = (v.kind == 2);
    mem_funct3_e_i   = v.f3;
    result_src_e_i   = (v.kind == 1) ? 5'b00100 : 5'b00001;
  endtask

  // Entered and left just after a falling edge.
  task automatic run_vec(input vec_t v);
    drive_ex(v);
    @(posedge clk); @(negedge clk);
    valid_e_i = 1'b0;
    if (v.kind == 0) begin
      chk("alu_stall", 32'(stall_m_o), 32'd0);
      chk("alu_req", 32'(dmem_req_o), 32'd0);
      @(posedge clk); @(negedge clk);
      chk("alu_wb_res", alu_result_m_o, v.addr);
      chk("alu_wb_imm", extended_imm_m_o, v.wd);
      chk("alu_wb_pc4", pc_plus4_m_o, v.addr + 32'd4);
      chk("alu_wb_csr", CSR_data_m_o, v.rdat);
      chk("alu_wb_rd", 32'(rd_idx_m_o), 32'(v.rd));
      chk("alu_wb_we", 32'(reg_write_en_m_o), 32'd1);
      chk("alu_wb_src", 32'(result_src_m_o), 32'd1);
    end else begin
      for (int i = 0; i <= v.gd; i++) begin
        chk("req", 32'(dmem_req_o), 32'd1);
        chk("dmem_we", 32'(dmem_we_o), 32'(v.kind == 2));
        chk("addr", dmem_addr_o, v.e_addr);
        if (v.kind == 2) begin
          chk("be", 32'(dmem_be_o), 32'(v.e_be));
          chk("wdata", dmem_wdata_o, v.e_wd);
        end
        chk("stall_wait_gnt", 32'(stall_m_o), 32'd1);
        if (i == v.gd) begin
          dmem_gnt_i = 1'b1;
          #1;
          chk("stall_at_gnt", 32'(stall_m_o), 32'(v.kind == 1));
        end
        @(posedge clk); @(negedge clk);
      end
      dmem_gnt_i = 1'b0;
      if (v.kind == 1) begin
        for (int i = 0; i <= v.rvd; i++) begin
          chk("rdata_req", 32'(dmem_req_o), 32'd0);
          chk("rdata_stall", 32'(stall_m_o), 32'd1);
          chk("rdata_wb_bubble", 32'(reg_write_en_m_o), 32'd0);
          if (i == v.rvd) begin
            dmem_rvalid_i = 1'b1;
            dmem_rdata_i  = v.rdat;
            #1;
            chk("stall_at_rvalid", 32'(stall_m_o), 32'd0);
          end
          @(posedge clk); @(negedge clk);
        end
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = $urandom;
        chk("ld_data", mem_read_data_m_o, v.e_ld);
      end
      chk("mem_wb_rd", 32'(rd_idx_m_o), 32'(v.rd));
      chk("mem_wb_we", 32'(reg_write_en_m_o), 32'd1);
      chk("mem_wb_src", 32'(result_src_m_o), (v.kind == 1) ? 32'd4 : 32'd1);
      chk("mem_wb_alu", alu_result_m_o, v.addr);
      chk("idle_req", 32'(dmem_req_o), 32'd0);
    end
  endtask

  // Memory op in M stalls while a non-memory op waits in EX; both must retire in order.
  task automatic hold_seq(input bit ld, input int gd);
    vec_t m, a;
    m = mk(ld ? 1 : 2, 3'd2, 32'h300, 32'h55, 32'h0, 0, 0, 0, 0, 0, 0);
    m.rd = 5'd3;
    a = mk(0, 3'd0, 32'h1234, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0);
    a.rd = 5'd7;
    drive_ex(m);
    reg_write_en_e_i = ld;
    @(posedge clk); @(negedge clk);
    drive_ex(a);
    for (int i = 0; i <= gd; i++) begin
      chk("hold_req", 32'(dmem_req_o), 32'd1);
      chk("hold_addr", dmem_addr_o, 32'h300);
      chk("hold_be", 32'(dmem_be_o), 32'hF);
      chk("hold_wdata", dmem_wdata_o, 32'h55);
      chk("hold_stall", 32'(stall_m_o), 32'd1);
      chk("hold_wb_bubble", 32'(reg_write_en_m_o), 32'd0);
      if (i == gd) dmem_gnt_i = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    dmem_gnt_i = 1'b0;
    if (ld) begin
      chk("hold_rd_stall", 32'(stall_m_o), 32'd1);
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i  = 32'hCAFE_0001;
      @(posedge clk); @(negedge clk);
      dmem_rvalid_i = 1'b0;
    end
    valid_e_i = 1'b0;
    chk("hold_next_stall", 32'(stall_m_o), 32'd0);
    chk("hold_next_req", 32'(dmem_req_o), 32'd0);
    chk("hold_wb1_rd", 32'(rd_idx_m_o), 32'd3);
    chk("hold_wb1_we", 32'(reg_write_en_m_o), 32'(ld));
    if (ld) chk("hold_wb1_ld", mem_read_data_m_o, 32'hCAFE_0001);
    @(posedge clk); @(negedge clk);
    chk("hold_wb2_rd", 32'(rd_idx_m_o), 32'd7);
    chk("hold_wb2_we", 32'(reg_write_en_m_o), 32'd1);
    chk("hold_wb2_alu", alu_result_m_o, 32'h1234);
  endtask

  vec_t tbl[11];

  initial begin
    vec_t v;
    tbl[0]  = mk(1, 3'd2, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0, 32'h100, 4'hF, 32'h0, 32'hDEAD_BEEF);
    tbl[1]  = mk(1, 3'd0, 32'h103, 32'h0, 32'h80FF_1234, 0, 1, 32'h100, 4'h0, 32'h0, 32'hFFFF_FF80);
    tbl[2]  = mk(1, 3'd4, 32'h103, 32'h0, 32'h80FF_1234, 1, 0, 32'h100, 4'h0, 32'h0, 32'h0000_0080);
    tbl[3]  = mk(1, 3'd5, 32'h102, 32'h0, 32'h80FF_1234, 0, 0, 32'h100, 4'h0, 32'h0, 32'h0000_80FF);
    tbl[4]  = mk(1, 3'd1, 32'h102, 32'h0, 32'h80FF_1234, 2, 2, 32'h100, 4'h0, 32'h0, 32'hFFFF_80FF);
    tbl[5]  = mk(1, 3'd3, 32'h108, 32'h0, 32'h1234_5678, 0, 0, 32'h108, 4'h0, 32'h0, 32'h1234_5678);
    tbl[6]  = mk(2, 3'd0, 32'h202, 32'h0000_00AB, 32'h0, 0, 0, 32'h200, 4'b0100, 32'hABAB_ABAB, 32'h0);
    tbl[7]  = mk(2, 3'd1, 32'h202, 32'h1234_CDEF, 32'h0, 0, 0, 32'h200, 4'b1100, 32'hCDEF_CDEF, 32'h0);
    tbl[8]  = mk(2, 3'd2, 32'h204, 32'h1122_3344, 32'h0, 3, 0, 32'h204, 4'b1111, 32'h1122_3344, 32'h0);
    tbl[9]  = mk(2, 3'd5, 32'h20C, 32'hAABB_CCDD, 32'h0, 0, 0, 32'h20C, 4'b1111, 32'hAABB_CCDD, 32'h0);
    tbl[10] = mk(0, 3'd0, 32'hCAFE_BABE, 32'h0000_0123, 32'h0BAD_F00D, 0, 0, 0, 0, 0, 0);

    resetn = 1'b0; valid_e_i = 1'b0; flush_m_i = 1'b0;
    alu_result_e_i = '0; mem_wdata_e_i = '0; extended_imm_e_i = '0; pc_plus4_e_i = '0;
    CSR_data_e_i = '0; reg_write_en_e_i = 1'b0; rd_idx_e_i = '0; result_src_e_i = '0;
    mem_read_e_i = 1'b0; mem_write_e_i = 1'b0; mem_funct3_e_i = '0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(dmem_req_o), 32'd0);
    chk("rst_stall", 32'(stall_m_o), 32'd0);
    chk("rst_exc", 32'(misalign_exc_o), 32'd0);
    chk("rst_wb_we", 32'(reg_write_en_m_o), 32'd0);
    chk("rst_wb_src", 32'(result_src_m_o), 32'd0);
    chk("rst_wb_alu", alu_result_m_o, 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      tbl[i].rd = 5'(i + 10);
      run_vec(tbl[i]);
    end

    hold_seq(1'b0, 3);
    hold_seq(1'b1, 0);

    // Flushed instruction must leave a bubble.
    v = tbl[10];
    drive_ex(v);
    flush_m_i = 1'b1;
    @(posedge clk); @(negedge clk);
    flush_m_i = 1'b0; valid_e_i = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("flush_wb_we", 32'(reg_write_en_m_o), 32'd0);
    chk("flush_wb_src", 32'(result_src_m_o), 32'd0);

    // Reset while waiting for read data, then a stray rvalid.
    v = tbl[0];
    drive_ex(v);
    @(posedge clk); @(negedge clk);
    valid_e_i = 1'b0; dmem_gnt_i = 1'b1;
    @(posedge clk); @(negedge clk);
    dmem_gnt_i = 1'b0;
    chk("rdrst_pre_stall", 32'(stall_m_o), 32'd1);
    resetn = 1'b0;
    #1;
    chk("rdrst_stall", 32'(stall_m_o), 32'd0);
    chk("rdrst_req", 32'(dmem_req_o), 32'd0);
    chk("rdrst_wb_alu", alu_result_m_o, 32'd0);
    chk("rdrst_wb_rd", 32'(rd_idx_m_o), 32'd0);
    @(posedge clk); @(negedge clk);
    resetn = 1'b1; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hFFFF_FFFF;
    #1;
    chk("stray_stall", 32'(stall_m_o), 32'd0);
    @(posedge clk); @(negedge clk);
    dmem_rvalid_i = 1'b0;
    chk("stray_wb_we", 32'(reg_write_en_m_o), 32'd0);
    chk("stray_wb_ld", mem_read_data_m_o, 32'd0);
    run_vec(tbl[0]);

    // Misaligned word load.
    v = model(mk(1, 3'd2, 32'h101, 32'h0, 32'h7654_3210, 0, 0, 0, 0, 0, 0));
    v.rd = 5'd5;
`ifdef MEM_MISALIGN_TRAP_EN
    drive_ex(v);
    @(posedge clk); @(negedge clk);
    valid_e_i = 1'b0;
    chk("mis_exc", 32'(misalign_exc_o), 32'd1);
    chk("mis_req", 32'(dmem_req_o), 32'd0);
    chk("mis_stall", 32'(stall_m_o), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("mis_exc_gone", 32'(misalign_exc_o), 32'd0);
    chk("mis_wb_we", 32'(reg_write_en_m_o), 32'd0);
`else
    chk("mis_model_addr", v.e_addr, 32'h100);
    run_vec(v);
    chk("mis_exc_tied", 32'(misalign_exc_o), 32'd0);
`endif

    for (int i = 0; i < 40; i++) begin
      v = mk(int'($urandom_range(0, 2)), 3'($urandom_range(0, 7)), 32'h1000 + $urandom_range(0, 1023),
             $urandom, $urandom, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 0, 0, 0, 0);
`ifdef MEM_MISALIGN_TRAP_EN
      v.addr = v.addr & 32'hFFFF_FFFC;
`endif
      v.rd = 5'($urandom_range(1, 31));
      v = model(v);
      run_vec(v);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
